// File: rtl/acc_requester.sv
// acc_requester: per-core in-order FIFO of accumulate operations.
// The head is issued on its accumulator's valid/ready lane, and completion is reported one cycle later.
module acc_requester #(
  parameter int DEPTH     = 4,
  parameter int N_ACC     = 3,
  parameter int ROB_WIDTH = 6,
  localparam int ACC_W = (N_ACC > 1) ? $clog2(N_ACC) : 1,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enq_valid_i,
  output logic                 enq_ready_o,
  input  logic [ACC_W-1:0]     enq_acc_i,
  input  logic [31:0]          enq_data_i,
  input  logic [ROB_WIDTH-1:0] enq_tag_i,
  output logic [N_ACC-1:0]     acc_valid_o,
  input  logic [N_ACC-1:0]     acc_ready_i,
  output logic [32*N_ACC-1:0]  acc_data_o,
  output logic                 done_valid_o,
  output logic [ROB_WIDTH-1:0] done_tag_o,
  output logic                 empty_o
);

  logic [ACC_W-1:0]     mem_acc_q  [DEPTH];
  logic [31:0]          mem_data_q [DEPTH];
  logic [ROB_WIDTH-1:0] mem_tag_q  [DEPTH];

  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 done_valid_q, done_valid_d;
  logic [ROB_WIDTH-1:0] done_tag_q, done_tag_d;

  logic [ACC_W-1:0]     head_acc;
  logic [31:0]          head_data;
  logic [ROB_WIDTH-1:0] head_tag;
  logic                 push;
  logic                 pop;

  // Full is judged on the registered count alone; a same-cycle pop does not free a slot.
  assign enq_ready_o = count_q < CNT_W'(DEPTH);
  assign push        = enq_valid_i && enq_ready_o && !reset_i;
  assign pop         = |(acc_valid_o & acc_ready_i);

  assign head_acc  = mem_acc_q[rd_ptr_q];
  assign head_data = mem_data_q[rd_ptr_q];
  assign head_tag  = mem_tag_q[rd_ptr_q];

  generate
    for (genvar gi = 0; gi < N_ACC; gi++) begin : g_lane
      assign acc_valid_o[gi]         = !reset_i && (count_q != '0) && (head_acc == ACC_W'(gi));
      assign acc_data_o[32*gi +: 32] = head_data;
    end
  endgenerate

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    done_valid_d = pop;
    done_tag_d   = done_tag_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      done_tag_d = head_tag;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      done_valid_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      done_valid_q <= done_valid_d;
    end
    done_tag_q <= done_tag_d;
  end

  // Entry storage is never cleared; only the pointers define what is live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_acc_q[wr_ptr_q]  <= enq_acc_i;
      mem_data_q[wr_ptr_q] <= enq_data_i;
      mem_tag_q[wr_ptr_q]  <= enq_tag_i;
    end
  end

  assign done_valid_o = done_valid_q;
  assign done_tag_o   = done_tag_q;
  assign empty_o      = (count_q == '0) && !done_valid_q;

endmodule

// File: tb/tb_acc_requester.sv
// Bench for acc_requester: a queue-based model is checked on every negedge,
// and directed scenarios add literal expectations.
module tb_acc_requester;
  localparam int DEPTH = 4;
  localparam int N_ACC = 3;
  localparam int RW    = 6;

  logic                clk = 1'b0;
  logic                reset;
  logic                enq_valid;
  logic                enq_ready;
  logic [1:0]          enq_acc;
  logic [31:0]         enq_data;
  logic [RW-1:0]       enq_tag;
  logic [N_ACC-1:0]    acc_valid;
  logic [N_ACC-1:0]    acc_ready;
  logic [32*N_ACC-1:0] acc_data;
  logic                done_valid;
  logic [RW-1:0]       done_tag;
  logic                empty;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  acc_requester #(.DEPTH(DEPTH), .N_ACC(N_ACC), .ROB_WIDTH(RW)) dut (
    .clk_i(clk), .reset_i(reset),
    .enq_valid_i(enq_valid), .enq_ready_o(enq_ready),
    .enq_acc_i(enq_acc), .enq_data_i(enq_data), .enq_tag_i(enq_tag),
    .acc_valid_o(acc_valid), .acc_ready_i(acc_ready), .acc_data_o(acc_data),
    .done_valid_o(done_valid), .done_tag_o(done_tag), .empty_o(empty)
  );

  typedef struct {
    int          acc;
    logic [31:0] data;
    logic [RW-1:0] tag;
  } entry_t;

  entry_t        mq[$];
  bit            m_done = 1'b0;
  logic [RW-1:0] m_done_tag = '0;
  bit            chk_en = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of pending entries plus a one-cycle completion slot.
  always @(posedge clk) begin
    bit hs;
    bit full;
    if (reset) begin
      mq.delete();
      m_done = 1'b0;
      chk_en = 1'b1;
    end else begin
      full = (mq.size() >= DEPTH);
      hs   = (mq.size() > 0) && acc_ready[mq[0].acc];
      m_done = hs;
      if (hs) begin
        m_done_tag = mq[0].tag;
        void'(mq.pop_front());
      end
      if (enq_valid && !full) mq.push_back('{acc: int'(enq_acc), data: enq_data, tag: enq_tag});
    end
  end

  always @(negedge clk) begin
    logic [N_ACC-1:0] ev;
    if (chk_en) begin
      ev = '0;
      if (!reset && mq.size() > 0) ev[mq[0].acc] = 1'b1;
      check("acc_valid", 96'(acc_valid), 96'(ev));
      if (ev != '0)
        for (int l = 0; l < N_ACC; l++) check("acc_data", 96'(acc_data[32*l +: 32]), 96'(mq[0].data));
      check("enq_ready", 96'(enq_ready), 96'(mq.size() < DEPTH));
      check("done_valid", 96'(done_valid), 96'(m_done));
      if (m_done) check("done_tag", 96'(done_tag), 96'(m_done_tag));
      check("empty", 96'(empty), 96'(mq.size() == 0 && !m_done));
      $display("cyc t=%0t valid=%b ready=%b done=%b tag=%0d empty=%b cnt=%0d",
               $time, acc_valid, acc_ready, done_valid, done_tag, empty, mq.size());
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_enq(input bit v, input int a, input logic [31:0] d, input int t);
    enq_valid = v;
    enq_acc   = 2'(a);
    enq_data  = d;
    enq_tag   = RW'(t);
  endtask

  task automatic single_op();
    set_enq(1, 1, 32'h3F80_0000, 5);
    acc_ready = '0;
    step();
    enq_valid = 1'b0;
    @(negedge clk);
    check("single_valid", 96'(acc_valid), 96'(3'b010));
    check("single_data", 96'(acc_data[63:32]), 96'(32'h3F80_0000));
    step();
    step();
    acc_ready = 3'b111;
    step();
    acc_ready = '0;
    @(negedge clk);
    check("single_done", 96'(done_valid), 96'(1));
    check("single_tag", 96'(done_tag), 96'(5));
    step();
    @(negedge clk);
    check("single_empty", 96'(empty), 96'(1));
  endtask

  initial begin
    reset = 1'b1;
    acc_ready = '0;
    set_enq(0, 0, 32'h0, 0);
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_enq_ready", 96'(enq_ready), 96'(1));
    check("rst_acc_valid", 96'(acc_valid), 96'(0));
    check("rst_done", 96'(done_valid), 96'(0));
    check("rst_empty", 96'(empty), 96'(1));

    single_op();

    // Stream with every accumulator ready.
    acc_ready = 3'b111;
    for (int i = 0; i < 4; i++) begin
      set_enq(1, i % 3, 32'h4000_0000 + 32'(i), i + 1);
      step();
      @(negedge clk);
      check("stream_valid", 96'(acc_valid), 96'(3'b001 << (i % 3)));
      if (i > 0) check("stream_tag", 96'(done_tag), 96'(i));
    end
    enq_valid = 1'b0;
    step();
    @(negedge clk);
    check("stream_last_tag", 96'(done_tag), 96'(4));

    // Fill, refuse on full even with a pop, then accept and wrap.
    acc_ready = '0;
    for (int i = 0; i < 5; i++) begin
      set_enq(1, i % 3, 32'h5000_0000 + 32'(i), 10 + i);
      step();
      if (i >= 3) begin
        @(negedge clk);
        check("fill_full", 96'(enq_ready), 96'(0));
      end
    end
    acc_ready = 3'b111;
    step();
    @(negedge clk);
    check("fullpop_ready", 96'(enq_ready), 96'(1));
    check("fullpop_tag", 96'(done_tag), 96'(10));
    acc_ready = '0;
    step();
    @(negedge clk);
    check("fullpop_refill", 96'(enq_ready), 96'(0));
    enq_valid = 1'b0;
    acc_ready = 3'b111;
    for (int i = 0; i < 6; i++) step();

    // Per-accumulator stall on lane 2.
    acc_ready = 3'b011;
    set_enq(1, 2, 32'hC0DE_0002, 20);
    step();
    set_enq(1, 0, 32'hC0DE_0000, 21);
    step();
    enq_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 96'(acc_valid), 96'(3'b100));
      check("stall_data", 96'(acc_data[95:64]), 96'(32'hC0DE_0002));
      step();
    end
    acc_ready = 3'b111;
    step();
    @(negedge clk);
    check("stall_tag0", 96'(done_tag), 96'(20));
    step();
    @(negedge clk);
    check("stall_tag1", 96'(done_tag), 96'(21));
    step();

    // Reset with three buffered entries and ready high.
    acc_ready = '0;
    for (int i = 0; i < 3; i++) begin
      set_enq(1, i, 32'h7000_0000 + 32'(i), 30 + i);
      step();
    end
    enq_valid = 1'b0;
    acc_ready = 3'b111;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", 96'(acc_valid), 96'(0));
    step();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_empty", 96'(empty), 96'(1));
    check("midrst_ready", 96'(enq_ready), 96'(1));
    check("midrst_done", 96'(done_valid), 96'(0));
    single_op();

    for (int i = 0; i < 3; i++) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
